spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of clk flops synchronizing sck, mosi and ss_n (legal 2..3).
REQ-002 SHALL provide port clk  input  1  single system clock; all logic on posedge clk.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port sck  input  1  SPI serial clock from master, asynchronous to clk.
REQ-005 SHALL provide port mosi  input  1  master-out data, MSB first.
REQ-006 SHALL provide port miso  output  1  slave-out data, MSB first.
REQ-007 SHALL provide port ss_n  input  1  slave select, active low.
REQ-008 SHALL provide port cpol  input  1  0: sck idles low; 1: sck idles high.
REQ-009 SHALL provide port cpha  input  1  0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge.
REQ-010 SHALL provide port tx_data  input  8  next byte to transmit.
REQ-011 SHALL provide port tx_load  input  1  one-cycle strobe writing tx_data into the tx buffer.
REQ-012 SHALL provide port tx_ready  output  1  tx buffer empty.
REQ-013 SHALL provide port rx_data  output  8  last complete received byte.
REQ-014 SHALL provide port rx_valid  output  1  rx_data unread; level signal.
REQ-015 SHALL provide port rx_ack  input  1  host has consumed rx_data.
REQ-016 SHALL provide port busy  output  1  transfer in progress (synchronized ss_n low).
REQ-017 SHALL provide port overrun  output  1  sticky overrun flag.

Function
REQ-018 SHALL detect sck edges by comparing the last two synchronized sck samples; leading edge = transition away from cpol, trailing edge = transition toward cpol.
REQ-019 SHALL implement states IDLE and SHIFT: IDLE->SHIFT on synchronized ss_n falling; SHIFT->IDLE on synchronized ss_n rising.
REQ-020 SHALL, on IDLE->SHIFT, copy the tx buffer into the tx shifter (0x00 if tx_ready=1), set tx_ready=1, clear the bit counter, and for cpha=0 drive miso = shifter[7] in the same cycle.
REQ-021 SHALL shift mosi into the rx shifter LSB on each sample edge and increment a 3-bit counter.
REQ-022 SHALL update miso from the tx shifter on each shift edge; for cpha=1 the first leading edge presents bit 7.
REQ-023 SHALL, on the clk cycle after the 8th sample edge is detected, load rx_data, set rx_valid=1, wrap the counter to 0 and reload the tx shifter as in REQ-020.
REQ-024 SHALL continue byte-after-byte while ss_n stays low.
REQ-025 SHALL clear rx_valid on rx_ack; if rx_ack coincides with byte completion, rx_valid remains 1 with the new byte.
REQ-026 SHALL accept tx_load only when tx_ready=1 (buffer written, tx_ready=0 next cycle); tx_load with tx_ready=0 is ignored.
REQ-027 SHALL, on ss_n deassertion mid-byte, discard the partial byte, leave rx_data/rx_valid unchanged, and reset the counter.
REQ-028 SHALL drive miso=0 in IDLE.
REQ-029 SHALL require sck frequency <= clk/8; behaviour above that is undefined.

Reset
REQ-030 SHALL on reset enter IDLE with miso=0, rx_data=0x00, rx_valid=0, tx_ready=1, busy=0, overrun=0, counter=0, shifters cleared, synchronizers loaded to ss_n=1 and sck=cpol.
REQ-031 SHALL let reset mid-transfer abort immediately; the next transfer starts only on a fresh ss_n falling edge.

Configuration
REQ-032 SHALL, with SPI_SLAVE_OVERRUN_EN defined, set overrun=1 when a byte completes while rx_valid=1 and rx_ack=0, clearing it only on rx_ack or reset.
REQ-033 SHALL, without SPI_SLAVE_OVERRUN_EN, tie overrun to 0 and overwrite rx_data silently.

Verification
REQ-034 SHALL cover mode 0 (cpol=0,cpha=0): tx_load 0xA5, master sends 0x3C -> rx_data=0x3C, rx_valid=1, master receives 0xA5.
REQ-035 SHALL cover modes 1, 2 and 3 with master 0x96 / slave 0x69 -> exact exchange in each mode.
REQ-036 SHALL cover back-to-back bytes 0x01,0x02 with one ss_n window, no second tx_load -> rx 0x01 then 0x02, master receives tx byte then 0x00.
REQ-037 SHALL cover ss_n raised after 4 bits -> rx_valid stays 0, next full byte 0xF0 received correctly.
REQ-038 SHALL cover two bytes without rx_ack, macro defined -> overrun=1, rx_data=second byte; macro undefined -> overrun=0.
REQ-039 SHALL cover reset asserted after 5 bits -> all outputs at reset values next cycle, subsequent byte 0x55 received correctly.

Source files
------------

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pins and host-side byte interface for spi_slave
interface spi_slave_if;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       ss_n;
    logic       cpol;
    logic       cpha;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       overrun;

    modport slave (
        input  sck, mosi, ss_n, cpol, cpha, tx_data, tx_load, rx_ack,
        output miso, tx_ready, rx_data, rx_valid, busy, overrun
    );

    modport master (
        output sck, mosi, ss_n, cpol, cpha, tx_data, tx_load, rx_ack,
        input  miso, tx_ready, rx_data, rx_valid, busy, overrun
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI slave, modes 0-3, single tx buffer and rx holding register
// Optional sticky overrun flag enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        reset,
    spi_slave_if.slave bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;

    logic       sck_prev_q, sck_prev_d;
    logic       ss_prev_q, ss_prev_d;
    logic       sync_live_q, sync_live_d;
    logic       ss_armed_q, ss_armed_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ready_q, tx_ready_d;
    logic       miso_q, miso_d;
    logic       byte_done_q, byte_done_d;

    logic       sck_s, mosi_s, ss_s;
    logic       lead_edge, trail_edge, sample_edge, shift_edge;
    logic       ss_fall, ss_rise;
    logic [7:0] tx_next;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];

    assign lead_edge   = (sck_prev_q == bus.cpol) && (sck_s != bus.cpol);
    assign trail_edge  = (sck_prev_q != bus.cpol) && (sck_s == bus.cpol);
    assign sample_edge = bus.cpha ? trail_edge : lead_edge;
    assign shift_edge  = bus.cpha ? lead_edge : trail_edge;

    // A select that was already low when reset released must not start a transfer:
    // only arm once the live pin has been seen high.
    assign ss_fall = ss_armed_q && ss_prev_q && !ss_s;
    assign ss_rise = !ss_prev_q && ss_s;

    assign tx_next = tx_ready_q ? 8'h00 : tx_buf_q;

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.ss_n};
        sck_prev_d  = sck_s;
        ss_prev_d   = ss_s;
        sync_live_d = 1'b1;
        ss_armed_d  = ss_armed_q | (sync_live_q & ss_sync_q[0]);
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        tx_ready_d  = tx_ready_q;
        miso_d      = miso_q;
        byte_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = 3'd0;
                if (ss_fall) begin
                    state_d    = SHIFT;
                    tx_ready_d = 1'b1;
                    // cpha=0 drives bit 7 now, so the trailing edges only need bits 6..0
                    if (bus.cpha) begin
                        tx_shift_d = tx_next;
                    end else begin
                        tx_shift_d = {tx_next[6:0], 1'b0};
                        miso_d     = tx_next[7];
                    end
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    miso_d    = 1'b0;
                    bit_cnt_d = 3'd0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d  = {rx_shift_q[6:0], mosi_s};
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        byte_done_d = (bit_cnt_q == 3'd7);
                    end
                    if (shift_edge) begin
                        miso_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    // Full byte kept here: with cpha=0 the pending trailing edge re-presents bit 7
                    if (byte_done_q) begin
                        tx_shift_d = tx_next;
                        tx_ready_d = 1'b1;
                        if (!bus.cpha) begin
                            miso_d = tx_next[7];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.rx_ack) begin
            rx_valid_d = 1'b0;
        end
        if (byte_done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        if (bus.tx_load && tx_ready_q) begin
            tx_buf_d   = bus.tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sck_sync_q  <= {SYNC_STAGES{bus.cpol}};
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sck_prev_q  <= bus.cpol;
            ss_prev_q   <= 1'b1;
            sync_live_q <= 1'b0;
            ss_armed_q  <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            tx_buf_q    <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b1;
            miso_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sck_prev_q  <= sck_prev_d;
            ss_prev_q   <= ss_prev_d;
            sync_live_q <= sync_live_d;
            ss_armed_q  <= ss_armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            miso_q      <= miso_d;
            byte_done_q <= byte_done_d;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (byte_done_q && rx_valid_q && !bus.rx_ack) begin
            overrun_d = 1'b1;
        end else if (bus.rx_ack) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.miso     = miso_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized scoreboard bench for spi_slave
module tb_spi_slave;
    localparam int H = 80;

`ifdef SPI_SLAVE_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    spi_slave_if bus ();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] mosi_q[$];
    logic       auto_ack = 1'b1;
    logic       model_loaded = 1'b0;
    logic [7:0] model_buf = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every byte the DUT presents is matched against the next expected one
    initial begin
        bus.rx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rx_ack) begin
                bus.rx_ack = 1'b0;
            end else if (!reset && auto_ack && bus.rx_valid) begin
                if (rx_exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got 0x%0h expected none", bus.rx_data);
                end else begin
                    chk("rx_byte", {24'h0, bus.rx_data}, {24'h0, rx_exp_q.pop_front()});
                end
                bus.rx_ack = 1'b1;
            end
        end
    end

    task automatic set_mode(input int m);
        bus.cpol = m[1];
        bus.cpha = m[0];
        bus.sck  = m[1];
        repeat (4) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        chk("tx_ready_before_load", {31'h0, bus.tx_ready}, {31'h0, !model_loaded});
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
        if (!model_loaded) begin
            model_buf    = v;
            model_loaded = 1'b1;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        if (!bus.cpha) begin
            bus.mosi = tx[7];
            #(H/2);
        end
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!bus.cpha) begin
                bus.sck = ~bus.cpol;
                rx[i]   = bus.miso;
                #H;
                bus.sck = bus.cpol;
                if (i > 0) bus.mosi = tx[i-1];
                #H;
            end else begin
                bus.sck  = ~bus.cpol;
                bus.mosi = tx[i];
                #H;
                bus.sck = bus.cpol;
                rx[i]   = bus.miso;
                #H;
            end
        end
    endtask

    task automatic ss_low();
        bus.ss_n = 1'b0;
        #H;
    endtask

    task automatic ss_high();
        #H;
        bus.ss_n = 1'b1;
        #(4*H);
    endtask

    // One select window carrying every byte queued in mosi_q
    task automatic window();
        logic [7:0] b, got, exp_miso;
        ss_low();
        chk("busy_in_window", {31'h0, bus.busy}, 32'h1);
        while (mosi_q.size() != 0) begin
            b        = mosi_q.pop_front();
            exp_miso = model_loaded ? model_buf : 8'h00;
            model_loaded = 1'b0;
            if (auto_ack) rx_exp_q.push_back(b);
            spi_bits(b, 8, got);
            chk("miso_byte", {24'h0, got}, {24'h0, exp_miso});
        end
        ss_high();
        chk("miso_idle", {31'h0, bus.miso}, 32'h0);
        chk("busy_idle", {31'h0, bus.busy}, 32'h0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_miso"},     {31'h0, bus.miso},     32'h0);
        chk({tag, "_rx_data"},  {24'h0, bus.rx_data},  32'h0);
        chk({tag, "_rx_valid"}, {31'h0, bus.rx_valid}, 32'h0);
        chk({tag, "_tx_ready"}, {31'h0, bus.tx_ready}, 32'h1);
        chk({tag, "_busy"},     {31'h0, bus.busy},     32'h0);
        chk({tag, "_overrun"},  {31'h0, bus.overrun},  32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        int nb;
        bus.ss_n = 1'b1;  bus.sck = 1'b0;   bus.mosi = 1'b0;
        bus.cpol = 1'b0;  bus.cpha = 1'b0;
        bus.tx_data = 8'h00; bus.tx_load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Mode 0 exchange; the second load hits a full buffer and is ignored
        set_mode(0);
        load(8'hA5);
        load(8'hFF);
        mosi_q.push_back(8'h3C);
        window();
        chk("tx_ready_after_use", {31'h0, bus.tx_ready}, 32'h1);

        for (int m = 1; m < 4; m++) begin
            set_mode(m);
            load(8'h69);
            mosi_q.push_back(8'h96);
            window();
        end

        // Back-to-back bytes in one window, only the first has a loaded tx byte
        set_mode(0);
        load(8'h7E);
        mosi_q.push_back(8'h01);
        mosi_q.push_back(8'h02);
        window();

        // Partial byte is discarded
        ss_low();
        model_loaded = 1'b0;
        spi_bits(8'hAA, 4, got);
        ss_high();
        chk("partial_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
        mosi_q.push_back(8'hF0);
        window();

        // Two bytes with no acknowledge
        auto_ack = 1'b0;
        mosi_q.push_back(8'hC3);
        mosi_q.push_back(8'h5A);
        window();
        chk("ovr_rx_valid", {31'h0, bus.rx_valid}, 32'h1);
        chk("ovr_rx_data",  {24'h0, bus.rx_data},  32'h5A);
        chk("ovr_flag",     {31'h0, bus.overrun},  {31'h0, EXP_OVR});
        rx_exp_q.push_back(8'h5A);
        auto_ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovr_cleared",  {31'h0, bus.overrun},  32'h0);
        chk("ack_rx_valid", {31'h0, bus.rx_valid}, 32'h0);

        // Reset after 5 bits with select still low and a pending tx load
        set_mode(2);
        ss_low();
        model_loaded = 1'b0;
        spi_bits(8'hFF, 5, got);
        load(8'h33);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;
        model_loaded = 1'b0;
        spi_bits(8'h00, 3, got);
        chk("no_restart_busy", {31'h0, bus.busy}, 32'h0);
        ss_high();
        mosi_q.push_back(8'h55);
        window();

        for (int w = 0; w < 10; w++) begin
            set_mode(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) load(8'($urandom_range(0, 255)));
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k < nb; k++) mosi_q.push_back(8'($urandom_range(0, 255)));
            window();
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", rx_exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
